// File: rtl/imem_line_buffer.sv
// Instruction-side line buffer: one fully-associative line. Fetches that hit are
// answered from the held line. Fetches that miss first pull the whole line from
// pmem as a burst of BEATS beats, then answer.
module imem_line_buffer #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic [31:0]       imem_address,
  output logic [31:0]       imem_rdata,
  output logic              imem_resp,
  output logic              pmem_read,
  output logic [31:0]       pmem_address,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int LINE_W     = BEATS * BEAT_W;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int WSEL_W     = OFF_W - 2;
  localparam int WORDS      = LINE_W / 32;
  localparam int CNT_W      = $clog2(BEATS);
  localparam int TAG_W      = 32 - OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [31:2]         req_addr_q, req_addr_d;
  logic                valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                resp_q, resp_d;
  logic                pread_q, pread_d;
  logic [31:0]         paddr_q, paddr_d;

  // Byte-offset bits below the word are not needed.
  logic unused_addr_lo;
  assign unused_addr_lo = ^imem_address[1:0];

  // Pick 32-bit word w out of a line.
  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                           input logic [WSEL_W-1:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (w == WSEL_W'(i)) r = line[32*i +: 32];
    end
    return r;
  endfunction

  // Next-state, fill and response logic.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    rdata_d    = rdata_q;
    resp_d     = 1'b0;
    pread_d    = pread_q;
    paddr_d    = paddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (imem_read) begin
          req_addr_d = imem_address[31:2];
          if (valid_q && (tag_q == imem_address[31:OFF_W])) begin
            rdata_d = sel_word(line_q, imem_address[OFF_W-1:2]);
            resp_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            pread_d = 1'b1;
            paddr_d = {imem_address[31:OFF_W], {OFF_W{1'b0}}};
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (pmem_resp) begin
          for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) line_d[b*BEAT_W +: BEAT_W] = pmem_rdata;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            // Answer from the assembled line, including the beat landing now.
            pread_d = 1'b0;
            valid_d = 1'b1;
            tag_d   = req_addr_q[31:OFF_W];
            rdata_d = sel_word(line_d, req_addr_q[OFF_W-1:2]);
            resp_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      pread_q <= 1'b0;
      paddr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      pread_q <= pread_d;
      paddr_q <= paddr_d;
    end
  end

  // Line storage and captured request address carry no reset.
  always_ff @(posedge clk) begin
    line_q     <= line_d;
    req_addr_q <= req_addr_d;
  end

  assign imem_rdata   = rdata_q;
  assign imem_resp    = resp_q;
  assign pmem_read    = pread_q;
  assign pmem_address = paddr_q;

endmodule

// File: tb/tb_imem_line_buffer.sv
// Bench for imem_line_buffer: a one-line cache model predicts each response word.
// Directed fetches carry hand-computed literal expectations as well.
module tb_imem_line_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  imem_line_buffer #(.BEATS(4), .BEAT_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Model: one line of four 64-bit beats, a valid flag and a tag.
  logic [63:0] m_line [4];
  bit          m_valid = 0;
  logic [26:0] m_tag   = '0;
  logic [31:0] exp_q [$];

  // Burst contents and per-beat idle gaps for the next miss.
  logic [63:0] cur_beats [4];
  int          cur_gaps  [4];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction

  // Every response word is checked against the model's prediction.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (imem_resp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp with rdata %h, expected no response", imem_rdata);
        end else begin
          chk("rdata_model", imem_rdata, exp_q.pop_front());
        end
      end
      if (pmem_read) chk("pmem_addr_aligned", {27'b0, pmem_address[4:0]}, 32'h0);
    end
  end

  task automatic fetch(input logic [31:0] addr, output logic [31:0] got);
    bit hit;
    int w;
    logic [63:0] beat;
    hit = m_valid && (m_tag == addr[31:5]);
    if (!hit) begin
      for (int b = 0; b < 4; b++) m_line[b] = cur_beats[b];
      m_valid = 1;
      m_tag   = addr[31:5];
    end
    w    = int'(addr[4:2]);
    beat = m_line[w / 2];
    exp_q.push_back((w % 2) ? beat[63:32] : beat[31:0]);

    @(posedge clk); #1;
    imem_read    = 1'b1;
    imem_address = addr;
    @(posedge clk); #1;
    chk("pmem_read_after_req", {31'b0, pmem_read}, hit ? 32'd0 : 32'd1);
    if (!hit) begin
      chk("pmem_address", pmem_address, {addr[31:5], 5'b0});
      for (int k = 0; k < 4; k++) begin
        for (int g = 0; g < cur_gaps[k]; g++) begin
          pmem_resp = 1'b0;
          @(posedge clk); #1;
          chk("pmem_read_in_gap", {31'b0, pmem_read}, 32'd1);
          chk("no_early_resp", {31'b0, imem_resp}, 32'd0);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = cur_beats[k];
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (k < 3) chk("pmem_read_mid_burst", {31'b0, pmem_read}, 32'd1);
      end
      chk("pmem_read_dropped", {31'b0, pmem_read}, 32'd0);
    end
    chk("resp_latency", {31'b0, imem_resp}, 32'd1);
    got = imem_rdata;
    imem_read = 1'b0;
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'b0, imem_resp}, 32'd0);
  endtask

  logic [31:0] got;

  initial begin
    rst          = 1'b1;
    imem_read    = 1'b0;
    imem_address = '0;
    pmem_rdata   = '0;
    pmem_resp    = 1'b0;
    cur_gaps     = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_resp", {31'b0, imem_resp}, 32'd0);
    chk("rst_imem_rdata", imem_rdata, 32'd0);
    chk("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    chk("rst_pmem_address", pmem_address, 32'd0);
    rst     = 1'b0;
    started = 1;

    // Cold miss at 0x60, back-to-back beats.
    cur_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    fetch(32'h60, got);
    chk("t1_word0", got, 32'h1111_1111);
    // Hit on the same line, word 3 = high half of beat 1.
    fetch(32'h6C, got);
    chk("t2_hit_word3", got, 32'h2222_2222);
    fetch(32'h70, got);
    chk("t2_hit_word4", got, 32'h3333_3333);

    // Different line replaces the only line; old line then misses.
    cur_beats = '{64'hB0B0_0001_A0A0_0000, 64'hB1B1_0003_A1A1_0002,
                  64'hB2B2_0005_A2A2_0004, 64'hB3B3_0007_A3A3_0006};
    fetch(32'h80, got);
    chk("t3_new_line", got, 32'hA0A0_0000);
    cur_beats = '{64'hD0D0_0101_C0C0_0100, 64'hD1D1_0103_C1C1_0102,
                  64'hD2D2_0105_C2C2_0104, 64'hD3D3_0107_C3C3_0106};
    fetch(32'h64, got);
    chk("t3_old_line_refetch", got, 32'hD0D0_0101);

    // Burst with idle gaps between beats.
    cur_beats = '{64'h9000_0001_8000_0000, 64'h9000_0003_8000_0002,
                  64'h9000_0005_8000_0004, 64'h9000_0007_8000_0006};
    cur_gaps  = '{1, 2, 0, 2};
    fetch(32'h108, got);
    chk("t4_gapped_word2", got, 32'h8000_0002);
    cur_gaps  = '{0, 0, 0, 0};

    // Reset in the middle of a fill.
    @(posedge clk); #1;
    imem_read    = 1'b1;
    imem_address = 32'h60;
    @(posedge clk); #1;
    chk("t5_fill_started", {31'b0, pmem_read}, 32'd1);
    pmem_resp  = 1'b1;
    pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    chk("t5_rst_imem_resp", {31'b0, imem_resp}, 32'd0);
    m_valid = 0;
    @(posedge clk); #1;
    rst       = 1'b0;
    imem_read = 1'b0;

    // After reset 0x60 must burst again.
    cur_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    fetch(32'h60, got);
    chk("t5_refetch_word0", got, 32'h1111_1111);

    // Unaligned low bits ignored: 0x7E reads word 7.
    fetch(32'h7E, got);
    chk("t6_unaligned_word7", got, 32'h4444_4444);

    repeat (2) @(posedge clk);
    #1;
    chk("all_resps_seen", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
